// File: rtl/frame_sram_arbiter.sv
// frame_sram_arbiter: shares the frame SRAM single port between the host
// preload/readback path and the read-only sampling engine. Grants are
// combinational in the request cycle; read data returns one cycle later,
// steered to whichever requester issued the read.
module frame_sram_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              e_req,
    input  logic [ADDR_W-1:0] e_addr,
    output logic              e_gnt,
    output logic              e_rvalid,
    output logic [DATA_W-1:0] e_rdata,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    output logic              sram_web,
    output logic              sram_oe,
    output logic              sram_cs,
    input  logic [DATA_W-1:0] sram_do
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    // State records who owned the previous cycle's grant.
    typedef enum logic [1:0] {S_IDLE, S_HOST, S_ENG} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt, w_burst_nxt;
    logic             w_h_gnt, w_e_gnt;
    logic             r_rd_h, r_rd_e;

    // Owner state and burst length register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Grant decision and next owner/burst; no grant is issued while in reset.
    always_comb begin
        w_h_gnt     = 1'b0;
        w_e_gnt     = 1'b0;
        w_state_nxt = S_IDLE;
        w_burst_nxt = '0;
        if (!rst) begin
            if (h_req && !e_req) begin
                w_h_gnt = 1'b1;
            end else if (e_req && !h_req) begin
                w_e_gnt = 1'b1;
            end else if (h_req && e_req) begin
                case (r_state)
                    S_HOST: begin
                        if (r_burst_cnt < MAX_CNT) w_h_gnt = 1'b1;
                        else                       w_e_gnt = 1'b1;
                    end
                    S_ENG: begin
                        if (r_burst_cnt < MAX_CNT) w_e_gnt = 1'b1;
                        else                       w_h_gnt = 1'b1;
                    end
                    default: w_h_gnt = 1'b1;
                endcase
            end
        end
        if (w_h_gnt) begin
            w_state_nxt = S_HOST;
            if (r_state == S_HOST)
                w_burst_nxt = (r_burst_cnt < MAX_CNT) ? r_burst_cnt + ONE_CNT : r_burst_cnt;
            else
                w_burst_nxt = ONE_CNT;
        end else if (w_e_gnt) begin
            w_state_nxt = S_ENG;
            if (r_state == S_ENG)
                w_burst_nxt = (r_burst_cnt < MAX_CNT) ? r_burst_cnt + ONE_CNT : r_burst_cnt;
            else
                w_burst_nxt = ONE_CNT;
        end
    end

    // Read-return tag: remembers which requester's read is on sram_do next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_h <= 1'b0;
            r_rd_e <= 1'b0;
        end else begin
            r_rd_h <= w_h_gnt && !h_we;
            r_rd_e <= w_e_gnt;
        end
    end

    // SRAM pin drive follows the granted requester; idle values otherwise.
    always_comb begin
        sram_a   = '0;
        sram_di  = '0;
        sram_web = 1'b1;
        sram_oe  = 1'b0;
        sram_cs  = 1'b0;
        if (w_h_gnt) begin
            sram_a   = h_addr;
            sram_di  = h_wdata;
            sram_web = ~h_we;
            sram_oe  = ~h_we;
            sram_cs  = 1'b1;
        end else if (w_e_gnt) begin
            sram_a   = e_addr;
            sram_oe  = 1'b1;
            sram_cs  = 1'b1;
        end
    end

    assign h_gnt    = w_h_gnt;
    assign e_gnt    = w_e_gnt;
    // Returned data is zeroed on the side that did not issue the read.
    assign h_rvalid = r_rd_h && !rst;
    assign e_rvalid = r_rd_e && !rst;
    assign h_rdata  = h_rvalid ? sram_do : '0;
    assign e_rdata  = e_rvalid ? sram_do : '0;

endmodule
